// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures memory words into a
// prefetch FIFO and presents them to decode. Optional range check: IMEM_BOUND_CHK_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MEM_WORDS  = 257
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FETCH_EN,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST_OUT,
  output logic [31:0] INST_PC,
  output logic        FETCH_FAULT
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef IMEM_BOUND_CHK_EN
  localparam bit BOUND_CHK = 1'b1;
`else
  localparam bit BOUND_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_HALT, S_RUN, S_FAULT} state_t;

  state_t                         state, state_n;
  logic [31:0]                    fpc;
  logic [CW-1:0]                  count;
  logic [PW-1:0]                  wr_ptr, rd_ptr;
  logic [FIFO_DEPTH-1:0][31:0]    fifo_pc, fifo_inst;
  logic                           out_of_range, push, pop;

  // With the check compiled out this folds to 0 and FAULT is unreachable.
  assign out_of_range = BOUND_CHK && ({2'b00, fpc[31:2]} >= MEM_WORDS);

  assign IMEM_ADDR  = {fpc[31:2], 2'b00};
  assign INST_VALID = (count != '0);
  assign INST_OUT   = INST_VALID ? fifo_inst[rd_ptr] : 32'h0;
  assign INST_PC    = INST_VALID ? fifo_pc[rd_ptr]   : 32'h0;

  assign pop  = INST_VALID & INST_READY;
  assign push = (state == S_RUN) & FETCH_EN & ~REDIRECT_VALID & ~out_of_range &
                ((count < CW'(FIFO_DEPTH)) | pop);

`ifdef IMEM_BOUND_CHK_EN
  assign FETCH_FAULT = (state == S_FAULT);
`else
  assign FETCH_FAULT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_HALT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_HALT:  if (FETCH_EN && !REDIRECT_VALID) state_n = S_RUN;
      S_RUN: begin
        if (!FETCH_EN)                           state_n = S_HALT;
        else if (!REDIRECT_VALID && out_of_range) state_n = S_FAULT;
      end
      S_FAULT: if (REDIRECT_VALID) state_n = S_RUN;
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fpc    <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (REDIRECT_VALID) begin
      // Flush wins over any pop/push this edge; the popped head is dropped.
      fpc    <= REDIRECT_PC & ~32'h3;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fpc    <= fpc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fpc;
      fifo_inst[wr_ptr] <= IMEM_DATA;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl (default build, range check disabled).
module tb_imem_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FETCH_EN;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        INST_VALID;
  logic        INST_READY;
  logic [31:0] INST_OUT;
  logic [31:0] INST_PC;
  logic        FETCH_FAULT;

  int checks = 0;
  int errors = 0;

  imem_fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MEM_WORDS(257)) dut (
    .CLK(CLK), .RST_N(RST_N), .FETCH_EN(FETCH_EN), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_DATA(IMEM_DATA), .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .INST_VALID(INST_VALID), .INST_READY(INST_READY), .INST_OUT(INST_OUT),
    .INST_PC(INST_PC), .FETCH_FAULT(FETCH_FAULT)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: a few fixed words, everything else is tagged by address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h02b1c393;
      32'h04:  return 32'h00c3e793;
      32'h2C:  return 32'h00c3e793;
      32'h20:  return 32'h0034a203;
      default: return 32'hA000_0000 ^ a;
    endcase
  endfunction

  assign IMEM_DATA = mem_word(IMEM_ADDR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL timeout: bench did not reach its summary");
  end

  initial begin
    RST_N = 1'b0; FETCH_EN = 1'b0; INST_READY = 1'b0;
    REDIRECT_VALID = 1'b0; REDIRECT_PC = 32'h0;
    repeat (3) step();
    chk("rst_valid", 32'(INST_VALID), 32'd0);
    chk("rst_out",   INST_OUT, 32'h0);
    chk("rst_pc",    INST_PC, 32'h0);
    chk("rst_addr",  IMEM_ADDR, 32'h0);
    chk("rst_fault", 32'(FETCH_FAULT), 32'd0);
    RST_N = 1'b1;
    step();
    chk("halt_idle_valid", 32'(INST_VALID), 32'd0);

    // Streaming: one instruction per cycle from PC 0
    FETCH_EN = 1'b1; INST_READY = 1'b1;
    step();
    chk("run_entry_valid", 32'(INST_VALID), 32'd0);
    step();
    chk("s0_pc",   INST_PC, 32'h0);
    chk("s0_out",  INST_OUT, 32'h02b1c393);
    chk("s0_addr", IMEM_ADDR, 32'h4);
    step();
    chk("s1_pc",  INST_PC, 32'h4);
    chk("s1_out", INST_OUT, 32'h00c3e793);
    step();
    chk("s2_pc", INST_PC, 32'h8);
    step();
    chk("s3_pc",  INST_PC, 32'hC);
    chk("s3_out", INST_OUT, 32'hA000_000C);

    // Stall: FIFO fills to 2, fetch PC and head hold
    INST_READY = 1'b0;
    step();
    chk("fill_addr", IMEM_ADDR, 32'h14);
    chk("fill_pc",   INST_PC, 32'hC);
    repeat (4) step();
    chk("stall_addr",  IMEM_ADDR, 32'h14);
    chk("stall_pc",    INST_PC, 32'hC);
    chk("stall_valid", 32'(INST_VALID), 32'd1);
    INST_READY = 1'b1;
    step();
    chk("drain0_pc", INST_PC, 32'h10);
    step();
    chk("drain1_pc", INST_PC, 32'h14);
    step();
    chk("drain2_pc", INST_PC, 32'h18);

    // Redirect while full and popping: flush, target two edges later
    REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h2C;
    step();
    REDIRECT_VALID = 1'b0;
    chk("redir_flush_valid", 32'(INST_VALID), 32'd0);
    chk("redir_addr",        IMEM_ADDR, 32'h2C);
    step();
    chk("redir_pc",  INST_PC, 32'h2C);
    chk("redir_out", INST_OUT, 32'h00c3e793);

    // Unaligned redirect target is truncated to the word
    REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h23;
    step();
    REDIRECT_VALID = 1'b0;
    chk("unal_addr",  IMEM_ADDR, 32'h20);
    chk("unal_valid", 32'(INST_VALID), 32'd0);
    step();
    chk("unal_pc",  INST_PC, 32'h20);
    chk("unal_out", INST_OUT, 32'h0034a203);

    // Fetch disabled for 3 edges: queued entries drain, fpc holds
    INST_READY = 1'b0;
    step();
    chk("pre_dis_addr", IMEM_ADDR, 32'h28);
    FETCH_EN = 1'b0;
    step();
    chk("dis0_addr", IMEM_ADDR, 32'h28);
    chk("dis0_pc",   INST_PC, 32'h20);
    INST_READY = 1'b1;
    step();
    chk("dis1_pc", INST_PC, 32'h24);
    step();
    chk("dis2_valid", 32'(INST_VALID), 32'd0);
    chk("dis2_out",   INST_OUT, 32'h0);
    chk("dis2_addr",  IMEM_ADDR, 32'h28);
    FETCH_EN = 1'b1;
    step();
    chk("reen_valid", 32'(INST_VALID), 32'd0);
    step();
    chk("reen_pc",  INST_PC, 32'h28);
    chk("reen_out", INST_OUT, 32'hA000_0028);

    // Fetch PC wraps modulo 2^32
    REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'hFFFF_FFFE;
    step();
    REDIRECT_VALID = 1'b0;
    chk("wrap_addr0", IMEM_ADDR, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc0",   INST_PC, 32'hFFFF_FFFC);
    chk("wrap_out0",  INST_OUT, 32'h5FFF_FFFC);
    chk("wrap_addr1", IMEM_ADDR, 32'h0);
    step();
    chk("wrap_pc1",  INST_PC, 32'h0);
    chk("wrap_out1", INST_OUT, 32'h02b1c393);
    chk("nofault",   32'(FETCH_FAULT), 32'd0);

    // Asynchronous reset mid-cycle clears outputs immediately
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", 32'(INST_VALID), 32'd0);
    chk("arst_pc",    INST_PC, 32'h0);
    chk("arst_out",   INST_OUT, 32'h0);
    chk("arst_addr",  IMEM_ADDR, 32'h0);
    #1;
    RST_N = 1'b1;
    step();
    chk("post_rst_valid", 32'(INST_VALID), 32'd0);
    step();
    chk("post_rst_pc",  INST_PC, 32'h0);
    chk("post_rst_out", INST_OUT, 32'h02b1c393);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
